ace_ccu_path_demux: RTL and testbench
=====================================

Name: ace_ccu_path_demux

Overview:
- Downstream of the ACE transaction decoder. Takes one ACE slave request plus the decoder's per-channel "shareable" flags.
- Routes AW/W/AR to one of two master ports: port 0 is the bypass to memory, port 1 is the CCU (snoop path).
- Merges B/R responses back to the slave.
- Keeps W beats aligned with their AW and prevents response reordering by locking each direction to one port while transactions are outstanding.

Parameters:
- MaxTrans, 8: max outstanding transactions per direction (write, read); sets counter width $clog2(MaxTrans+1).
- MaxWTrans, 4: depth of the W-routing FIFO (AW accepted but W last-beat not yet sent).
- slv_req_t, logic: ACE request struct, with aw/w/ar payloads, valids and b_ready/r_ready.
- slv_resp_t, logic: ACE response struct, with readies and b/r payloads and valids.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- slv_req_i  input  slv_req_t  request from master.
- slv_resp_o  output  slv_resp_t  response to master.
- snoop_aw_trs_i  input  1  decoder flag: 1 routes AW to CCU (port 1), 0 routes to bypass (port 0).
- snoop_ar_trs_i  input  1  decoder flag: same meaning for AR.
- mst_reqs_o  output  2 x slv_req_t  requests to [0]=bypass, [1]=CCU.
- mst_resps_i  input  2 x slv_resp_t  responses from [0]=bypass, [1]=CCU.

Behaviour:
- Reset (rst_ni=0 at clk edge):
  - All mst valids and all slv readies are 0.
  - Write and read counters are 0; direction registers are 0; AW/AR lock flags are clear; W FIFO is empty.
- AW select:
  - sel = snoop_aw_trs_i, sampled while slv aw_valid is 1 and no lock is held.
  - Once aw_valid is driven to a port without aw_ready, lock sel and hold aw_valid on that port until handshake, regardless of flag changes. Clear the lock on handshake.
- AW stall: slv aw_ready=0 and no mst aw_valid raised when any of:
  - w_cnt != 0 and sel != w_dir.
  - w_cnt == MaxTrans.
  - W FIFO is full.
  - Stalls are evaluated only when not locked. A locked AW is never withdrawn.
- AW handshake (mst[sel] aw_valid & aw_ready):
  - Combinational pass-through to slv aw_ready.
  - Push sel into the W FIFO; w_dir <= sel; w_cnt += 1.
- W routing:
  - W is routed only to the FIFO head port; slv w_ready = mst[head] w_ready.
  - When the FIFO is empty, w_ready=0 and no w_valid is raised. W therefore starts at the earliest 1 cycle after its AW handshake; there is no same-cycle bypass.
  - Pop on a handshake with w.last=1.
  - Simultaneous push and pop: occupancy is unchanged.
- B:
  - slv b = mst[w_dir] b; mst[!w_dir] b_ready=0.
  - On B handshake, w_cnt -= 1.
  - AW handshake and B handshake in the same cycle: w_cnt is unchanged.
  - w_cnt never underflows; a B handshake with w_cnt==0 is ignored. Assertion: this never occurs.
- AR:
  - Same scheme with snoop_ar_trs_i, r_dir and r_cnt; no FIFO.
  - r_cnt increments on AR handshake and decrements on an R handshake with r.last=1.
  - slv r = mst[r_dir] r; the other port's r_ready=0.
  - Stall when r_cnt != 0 and sel != r_dir, or r_cnt == MaxTrans.
- Latency: all payloads are combinational pass-through; 0 added cycles except the W-after-AW rule.
- Direction switch: allowed only when the relevant counter is 0. The first AW/AR after drain may take either port in that same cycle.
- Independence: read and write paths are fully independent; no cross-direction stall.
- Reset mid-operation: all state is cleared at the next edge. In-flight downstream transactions are dropped by system-level reset.

Test Plan:
- Single AW with snoop_aw_trs_i=0, 4-beat W, then B → all on port 0; w_ready stays 0 in the AW-handshake cycle; w_cnt goes 0→1→0.
- AR with flag=1, then AR with flag=0 while the first is outstanding → second AR stalls (ar_ready=0) until the first R with last=1; then it routes to port 0 in the same cycle r_cnt reaches 0.
- 8 AWs to port 1 with B withheld → 9th AW stalls at MaxTrans (ar/aw_ready=0). Stalls earlier at 4 if W is withheld (W FIFO full).
- AW to port 1 with mst aw_ready=0 for 3 cycles while the flag toggles → aw_valid stays on port 1, port 0 aw_valid never rises, and the handshake completes on port 1.
- Same-cycle AW handshake and B handshake on port 0 with w_cnt=2 → w_cnt remains 2.
- Assert rst_ni=0 with w_cnt=3, r_cnt=2, W FIFO at 2 → after 1 edge all counters are 0, the FIFO is empty, all valids/readies are 0, and the next AW goes to either port.

Source files
------------

// File: rtl/ace_ccu_path_demux.sv
// Routes one ACE slave port to a bypass port (0) or the CCU port (1), keeping W
// beats behind their AW and locking each direction to one port while busy.
package ace_ccu_path_demux_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

module ace_ccu_path_demux #(
  parameter int unsigned MaxTrans  = 8,
  parameter int unsigned MaxWTrans = 4,
  parameter type slv_req_t  = ace_ccu_path_demux_pkg::req_t,
  parameter type slv_resp_t = ace_ccu_path_demux_pkg::resp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  slv_req_t              slv_req_i,
  output slv_resp_t             slv_resp_o,
  input  logic                  snoop_aw_trs_i,
  input  logic                  snoop_ar_trs_i,
  output slv_req_t  [1:0]       mst_reqs_o,
  input  slv_resp_t [1:0]       mst_resps_i
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned PtrW = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
  localparam int unsigned OccW = $clog2(MaxWTrans + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);
  localparam logic [OccW-1:0] OccMax = OccW'(MaxWTrans);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxWTrans - 1);

  logic [CntW-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic            w_dir_q, w_dir_d, r_dir_q, r_dir_d;
  logic            aw_lock_q, aw_lock_d, aw_sel_q, aw_sel_d;
  logic            ar_lock_q, ar_lock_d, ar_sel_q, ar_sel_d;
  logic [MaxWTrans-1:0] wf_mem_q, wf_mem_d;
  logic [PtrW-1:0] wf_rd_q, wf_rd_d, wf_wr_q, wf_wr_d;
  logic [OccW-1:0] wf_cnt_q, wf_cnt_d;

  logic aw_sel, aw_stall, aw_go, aw_hs;
  logic ar_sel, ar_stall, ar_go, ar_hs;
  logic wf_full, wf_head, w_open, w_last_hs;
  logic b_hs, r_last_hs;

  // A held (locked) request is never re-evaluated against the stall terms.
  always_comb begin
    aw_sel   = aw_lock_q ? aw_sel_q : snoop_aw_trs_i;
    wf_full  = (wf_cnt_q == OccMax);
    aw_stall = !aw_lock_q && (((w_cnt_q != '0) && (aw_sel != w_dir_q)) ||
                              (w_cnt_q == CntMax) || wf_full);
    aw_go    = rst_ni && slv_req_i.aw_valid && !aw_stall;
    aw_hs    = aw_go && mst_resps_i[aw_sel].aw_ready;

    ar_sel   = ar_lock_q ? ar_sel_q : snoop_ar_trs_i;
    ar_stall = !ar_lock_q && (((r_cnt_q != '0) && (ar_sel != r_dir_q)) ||
                              (r_cnt_q == CntMax));
    ar_go    = rst_ni && slv_req_i.ar_valid && !ar_stall;
    ar_hs    = ar_go && mst_resps_i[ar_sel].ar_ready;

    wf_head   = wf_mem_q[wf_rd_q];
    w_open    = rst_ni && (wf_cnt_q != '0);
    w_last_hs = w_open && slv_req_i.w_valid && mst_resps_i[wf_head].w_ready &&
                slv_req_i.w.last;
    b_hs      = rst_ni && mst_resps_i[w_dir_q].b_valid && slv_req_i.b_ready;
    r_last_hs = rst_ni && mst_resps_i[r_dir_q].r_valid && slv_req_i.r_ready &&
                mst_resps_i[r_dir_q].r.last;
  end

  always_comb begin
    slv_resp_o = '0;
    mst_reqs_o = '0;
    for (int p = 0; p < 2; p++) begin
      mst_reqs_o[p].aw = slv_req_i.aw;
      mst_reqs_o[p].w  = slv_req_i.w;
      mst_reqs_o[p].ar = slv_req_i.ar;
    end
    mst_reqs_o[aw_sel].aw_valid = aw_go;
    slv_resp_o.aw_ready         = rst_ni && !aw_stall && mst_resps_i[aw_sel].aw_ready;
    mst_reqs_o[wf_head].w_valid = w_open && slv_req_i.w_valid;
    slv_resp_o.w_ready          = w_open && mst_resps_i[wf_head].w_ready;
    mst_reqs_o[w_dir_q].b_ready = rst_ni && slv_req_i.b_ready;
    slv_resp_o.b                = mst_resps_i[w_dir_q].b;
    slv_resp_o.b_valid          = rst_ni && mst_resps_i[w_dir_q].b_valid;
    mst_reqs_o[ar_sel].ar_valid = ar_go;
    slv_resp_o.ar_ready         = rst_ni && !ar_stall && mst_resps_i[ar_sel].ar_ready;
    mst_reqs_o[r_dir_q].r_ready = rst_ni && slv_req_i.r_ready;
    slv_resp_o.r                = mst_resps_i[r_dir_q].r;
    slv_resp_o.r_valid          = rst_ni && mst_resps_i[r_dir_q].r_valid;
  end

  always_comb begin
    aw_lock_d = aw_lock_q;
    aw_sel_d  = aw_sel_q;
    if (aw_hs) begin
      aw_lock_d = 1'b0;
    end else if (aw_go) begin
      aw_lock_d = 1'b1;
      aw_sel_d  = aw_sel;
    end
    ar_lock_d = ar_lock_q;
    ar_sel_d  = ar_sel_q;
    if (ar_hs) begin
      ar_lock_d = 1'b0;
    end else if (ar_go) begin
      ar_lock_d = 1'b1;
      ar_sel_d  = ar_sel;
    end

    // A response with nothing outstanding is dropped rather than wrapping the counter.
    w_dir_d = aw_hs ? aw_sel : w_dir_q;
    w_cnt_d = w_cnt_q;
    if (aw_hs && !(b_hs && (w_cnt_q != '0))) begin
      w_cnt_d = w_cnt_q + CntW'(1);
    end else if (!aw_hs && b_hs && (w_cnt_q != '0)) begin
      w_cnt_d = w_cnt_q - CntW'(1);
    end
    r_dir_d = ar_hs ? ar_sel : r_dir_q;
    r_cnt_d = r_cnt_q;
    if (ar_hs && !(r_last_hs && (r_cnt_q != '0))) begin
      r_cnt_d = r_cnt_q + CntW'(1);
    end else if (!ar_hs && r_last_hs && (r_cnt_q != '0)) begin
      r_cnt_d = r_cnt_q - CntW'(1);
    end

    wf_mem_d = wf_mem_q;
    wf_wr_d  = wf_wr_q;
    wf_rd_d  = wf_rd_q;
    wf_cnt_d = wf_cnt_q;
    if (aw_hs) begin
      wf_mem_d[wf_wr_q] = aw_sel;
      wf_wr_d = (wf_wr_q == PtrLast) ? '0 : wf_wr_q + PtrW'(1);
    end
    if (w_last_hs) begin
      wf_rd_d = (wf_rd_q == PtrLast) ? '0 : wf_rd_q + PtrW'(1);
    end
    if (aw_hs && !w_last_hs) begin
      wf_cnt_d = wf_cnt_q + OccW'(1);
    end else if (!aw_hs && w_last_hs) begin
      wf_cnt_d = wf_cnt_q - OccW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      w_dir_q   <= 1'b0;
      r_dir_q   <= 1'b0;
      aw_lock_q <= 1'b0;
      aw_sel_q  <= 1'b0;
      ar_lock_q <= 1'b0;
      ar_sel_q  <= 1'b0;
      wf_mem_q  <= '0;
      wf_rd_q   <= '0;
      wf_wr_q   <= '0;
      wf_cnt_q  <= '0;
    end else begin
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      w_dir_q   <= w_dir_d;
      r_dir_q   <= r_dir_d;
      aw_lock_q <= aw_lock_d;
      aw_sel_q  <= aw_sel_d;
      ar_lock_q <= ar_lock_d;
      ar_sel_q  <= ar_sel_d;
      wf_mem_q  <= wf_mem_d;
      wf_rd_q   <= wf_rd_d;
      wf_wr_q   <= wf_wr_d;
      wf_cnt_q  <= wf_cnt_d;
    end
  end

  b_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_hs && (w_cnt_q == '0)));
  r_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_last_hs && (r_cnt_q == '0)));

endmodule

// File: tb/tb_ace_ccu_path_demux.sv
// Directed bench: stimulus queues expected handshakes per channel, a negedge
// monitor pops and compares whatever the DUT actually hands over.
module tb_ace_ccu_path_demux;
  import ace_ccu_path_demux_pkg::*;

  localparam int CH_AW = 0, CH_W = 1, CH_AR = 2, CH_B = 3, CH_R = 4;

  typedef struct {
    int          port;
    logic [31:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  req_t slv_req;
  resp_t slv_resp;
  logic snoop_aw, snoop_ar;
  req_t [1:0] mst_reqs;
  resp_t [1:0] mst_resps;

  exp_t expq[5][$];
  int total = 0;
  int bad = 0;

  ace_ccu_path_demux dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .slv_req_i      (slv_req),
    .slv_resp_o     (slv_resp),
    .snoop_aw_trs_i (snoop_aw),
    .snoop_ar_trs_i (snoop_ar),
    .mst_reqs_o     (mst_reqs),
    .mst_resps_i    (mst_resps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int ch, input int port, input logic [31:0] tag);
    exp_t e;
    e.port = port;
    e.tag  = tag;
    expq[ch].push_back(e);
  endtask

  task automatic mon(input string nm, input int ch, input int port, input logic [31:0] tag);
    exp_t e;
    total++;
    if (expq[ch].size() == 0) begin
      bad++;
      $display("FAIL %s unexpected: port %0d tag %0h, expected nothing", nm, port, tag);
    end else begin
      e = expq[ch].pop_front();
      if (e.port != port || e.tag !== tag) begin
        bad++;
        $display("FAIL %s: got port %0d tag %0h expected port %0d tag %0h",
                 nm, port, tag, e.port, e.tag);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (mst_reqs[p].aw_valid && mst_resps[p].aw_ready) mon("aw", CH_AW, p, 32'(mst_reqs[p].aw.id));
        if (mst_reqs[p].w_valid && mst_resps[p].w_ready) mon("w", CH_W, p, mst_reqs[p].w.data);
        if (mst_reqs[p].ar_valid && mst_resps[p].ar_ready) mon("ar", CH_AR, p, 32'(mst_reqs[p].ar.id));
      end
      if (slv_resp.b_valid && slv_req.b_ready) mon("b", CH_B, 0, 32'(slv_resp.b.id));
      if (slv_resp.r_valid && slv_req.r_ready) mon("r", CH_R, 0, slv_resp.r.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w_beat(input int port, input logic [31:0] data);
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = data;
    slv_req.w.last  = 1'b1;
    push(CH_W, port, data);
    tick();
    slv_req.w_valid = 1'b0;
  endtask

  task automatic b_beats(input int port, input logic [3:0] id, input int n);
    mst_resps[port].b_valid = 1'b1;
    mst_resps[port].b.id    = id;
    for (int i = 0; i < n; i++) begin
      push(CH_B, 0, 32'(id));
      tick();
    end
    mst_resps[port].b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    slv_req = '0;
    mst_resps = '0;
    snoop_aw = 1'b0;
    snoop_ar = 1'b0;
    tick();
    tick();
    // Reset held with every input asking for a handshake.
    slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1; slv_req.ar_valid = 1'b1;
    slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      mst_resps[p].aw_ready = 1'b1; mst_resps[p].w_ready = 1'b1;
      mst_resps[p].ar_ready = 1'b1; mst_resps[p].b_valid = 1'b1; mst_resps[p].r_valid = 1'b1;
    end
    #1;
    chk("rst_mst_valids", 32'({mst_reqs[1].aw_valid, mst_reqs[0].aw_valid, mst_reqs[1].w_valid,
        mst_reqs[0].w_valid, mst_reqs[1].ar_valid, mst_reqs[0].ar_valid}), 0);
    chk("rst_slv_readies", 32'({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
        slv_resp.b_valid, slv_resp.r_valid}), 0);
    tick();
    slv_req = '0;
    for (int p = 0; p < 2; p++) begin
      mst_resps[p] = '0;
      mst_resps[p].aw_ready = 1'b1; mst_resps[p].w_ready = 1'b1; mst_resps[p].ar_ready = 1'b1;
    end
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("rst_counts", 32'({dut.w_cnt_q, dut.r_cnt_q, dut.wf_cnt_q}), 0);

    // 1: single write on the bypass, W waits one cycle for its AW.
    snoop_aw = 1'b0;
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd1;
    slv_req.w_valid = 1'b1; slv_req.w.data = 32'h100; slv_req.w.last = 1'b0;
    push(CH_AW, 0, 1);
    #1;
    chk("t1_aw_ready", 32'(slv_resp.aw_ready), 1);
    chk("t1_w_ready_in_aw_cycle", 32'(slv_resp.w_ready), 0);
    chk("t1_no_w_valid_in_aw_cycle", 32'({mst_reqs[1].w_valid, mst_reqs[0].w_valid}), 0);
    tick();
    slv_req.aw_valid = 1'b0;
    chk("t1_wcnt_one", 32'(dut.w_cnt_q), 1);
    for (int i = 0; i < 4; i++) begin
      slv_req.w.data = 32'h100 + 32'(i);
      slv_req.w.last = (i == 3);
      push(CH_W, 0, slv_req.w.data);
      tick();
    end
    slv_req.w_valid = 1'b0;
    mst_resps[1].b_valid = 1'b1; mst_resps[1].b.id = 4'd9;
    mst_resps[0].b_valid = 1'b1; mst_resps[0].b.id = 4'd1;
    push(CH_B, 0, 1);
    #1;
    chk("t1_other_b_ready", 32'(mst_reqs[1].b_ready), 0);
    tick();
    mst_resps[0].b_valid = 1'b0; mst_resps[1].b_valid = 1'b0;
    chk("t1_wcnt_zero", 32'(dut.w_cnt_q), 0);

    // 2: read direction change waits for the outstanding R last.
    snoop_ar = 1'b1;
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd2;
    push(CH_AR, 1, 2);
    tick();
    snoop_ar = 1'b0; slv_req.ar.id = 4'd3;
    #1;
    chk("t2_ar_stall_a", 32'(slv_resp.ar_ready), 0);
    tick();
    mst_resps[1].r_valid = 1'b1; mst_resps[1].r.data = 32'hA0; mst_resps[1].r.last = 1'b0;
    mst_resps[0].r_valid = 1'b1; mst_resps[0].r.data = 32'hEE; mst_resps[0].r.last = 1'b1;
    push(CH_R, 0, 32'hA0);
    #1;
    chk("t2_ar_stall_b", 32'(slv_resp.ar_ready), 0);
    chk("t2_p0_ar_quiet", 32'(mst_reqs[0].ar_valid), 0);
    tick();
    mst_resps[1].r.data = 32'hA1; mst_resps[1].r.last = 1'b1;
    push(CH_R, 0, 32'hA1);
    #1;
    chk("t2_ar_stall_rlast", 32'(slv_resp.ar_ready), 0);
    tick();
    mst_resps[0].r_valid = 1'b0; mst_resps[1].r_valid = 1'b0;
    push(CH_AR, 0, 3);
    #1;
    chk("t2_ar_after_drain", 32'(slv_resp.ar_ready), 1);
    tick();
    slv_req.ar_valid = 1'b0;
    mst_resps[0].r_valid = 1'b1; mst_resps[0].r.data = 32'hB0; mst_resps[0].r.last = 1'b1;
    push(CH_R, 0, 32'hB0);
    tick();
    mst_resps[0].r_valid = 1'b0;
    chk("t2_rcnt_zero", 32'(dut.r_cnt_q), 0);

    // 3a: eight writes to the CCU with B withheld, ninth stalls.
    snoop_aw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'(i);
      push(CH_AW, 1, i);
      tick();
      slv_req.aw_valid = 1'b0;
      w_beat(1, 32'h200 + 32'(i));
    end
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd8;
    #1;
    chk("t3_wcnt_max", 32'(dut.w_cnt_q), 8);
    chk("t3_aw_stall_max", 32'(slv_resp.aw_ready), 0);
    chk("t3_no_aw_valid_max", 32'({mst_reqs[1].aw_valid, mst_reqs[0].aw_valid}), 0);
    slv_req.aw_valid = 1'b0;
    b_beats(1, 4'd5, 8);
    chk("t3_wcnt_drained", 32'(dut.w_cnt_q), 0);

    // 3b: W withheld, fifth AW stalls on a full W FIFO, then rides a same-cycle push/pop.
    for (int i = 0; i < 4; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'(10 + i);
      push(CH_AW, 1, 10 + i);
      tick();
    end
    slv_req.aw.id = 4'd14;
    #1;
    chk("t3_wfifo_full", 32'(dut.wf_cnt_q), 4);
    chk("t3_aw_stall_fifo", 32'(slv_resp.aw_ready), 0);
    push(CH_AW, 1, 14);
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      slv_req.w.data = 32'h300 + 32'(i);
      push(CH_W, 1, slv_req.w.data);
      tick();
      if (i == 1) begin
        slv_req.aw_valid = 1'b0;
        chk("t3_push_pop_occ", 32'(dut.wf_cnt_q), 3);
      end
    end
    slv_req.w_valid = 1'b0;
    b_beats(1, 4'd6, 5);
    chk("t3_wfifo_empty", 32'({dut.w_cnt_q, dut.wf_cnt_q}), 0);

    // 4: AW locked to port 1 while the flag toggles.
    mst_resps[1].aw_ready = 1'b0;
    snoop_aw = 1'b1;
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_p1_aw_valid", 32'(mst_reqs[1].aw_valid), 1);
      chk("t4_p0_aw_quiet", 32'(mst_reqs[0].aw_valid), 0);
      tick();
      snoop_aw = ~snoop_aw;
    end
    mst_resps[1].aw_ready = 1'b1;
    push(CH_AW, 1, 6);
    #1;
    chk("t4_p0_aw_quiet_hs", 32'(mst_reqs[0].aw_valid), 0);
    tick();
    slv_req.aw_valid = 1'b0;
    w_beat(1, 32'h400);
    b_beats(1, 4'd6, 1);

    // 5: AW and B handshake together on port 0 with two outstanding.
    snoop_aw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'(7 + i);
      push(CH_AW, 0, 7 + i);
      tick();
    end
    slv_req.aw_valid = 1'b0;
    w_beat(0, 32'h500);
    w_beat(0, 32'h501);
    chk("t5_wcnt_two", 32'(dut.w_cnt_q), 2);
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd9;
    mst_resps[0].b_valid = 1'b1; mst_resps[0].b.id = 4'd7;
    push(CH_AW, 0, 9);
    push(CH_B, 0, 7);
    tick();
    slv_req.aw_valid = 1'b0; mst_resps[0].b_valid = 1'b0;
    chk("t5_wcnt_unchanged", 32'(dut.w_cnt_q), 2);
    w_beat(0, 32'h502);
    b_beats(0, 4'd8, 2);

    // 6: reset with traffic outstanding in both directions.
    snoop_ar = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'(i);
      push(CH_AW, 0, i);
      slv_req.ar_valid = (i < 3); slv_req.ar.id = 4'(i);
      if (i < 3) push(CH_AR, 0, i);
      if (i == 3) begin
        slv_req.w_valid = 1'b1; slv_req.w.data = 32'h600; slv_req.w.last = 1'b1;
        push(CH_W, 0, 32'h600);
      end
      tick();
    end
    slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0; slv_req.w_valid = 1'b0;
    chk("t6_pre_wcnt", 32'(dut.w_cnt_q), 3);
    chk("t6_pre_rcnt", 32'(dut.r_cnt_q), 2);
    chk("t6_pre_wfifo", 32'(dut.wf_cnt_q), 2);
    rst_n = 1'b0;
    tick();
    chk("t6_post_counts", 32'({dut.w_cnt_q, dut.r_cnt_q, dut.wf_cnt_q}), 0);
    slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1;
    #1;
    chk("t6_rst_quiet", 32'({slv_resp.aw_ready, slv_resp.w_ready, mst_reqs[0].aw_valid,
        mst_reqs[1].aw_valid, mst_reqs[0].w_valid, mst_reqs[1].w_valid}), 0);
    rst_n = 1'b1;
    slv_req.w_valid = 1'b0;
    snoop_aw = 1'b1; slv_req.aw.id = 4'd4;
    push(CH_AW, 1, 4);
    #1;
    chk("t6_new_dir_aw_ready", 32'(slv_resp.aw_ready), 1);
    tick();
    slv_req.aw_valid = 1'b0;
    w_beat(1, 32'h700);
    b_beats(1, 4'd4, 1);
    tick();

    chk("left_aw", 32'(expq[CH_AW].size()), 0);
    chk("left_w", 32'(expq[CH_W].size()), 0);
    chk("left_ar", 32'(expq[CH_AR].size()), 0);
    chk("left_b", 32'(expq[CH_B].size()), 0);
    chk("left_r", 32'(expq[CH_R].size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
